// File: rtl/psram_xfer_arb_if.sv
// psram_xfer_arb_if: transfer port between the arbiter and psram_core.
// master: arbiter side (drives cflg/xfer_valid/xfer_rdwr/addr/wdata/wmask,
//         receives xfer_ready/xfer_done/rd_data).
// slave : core side (mirror of master).
interface psram_xfer_arb_if;
    logic        cflg;
    logic        xfer_valid;
    logic        xfer_rdwr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        xfer_ready;
    logic        xfer_done;
    logic [63:0] rd_data;
    modport master (
        output cflg, xfer_valid, xfer_rdwr, addr, wdata, wmask,
        input  xfer_ready, xfer_done, rd_data
    );
    modport slave (
        input  cflg, xfer_valid, xfer_rdwr, addr, wdata, wmask,
        output xfer_ready, xfer_done, rd_data
    );
endinterface

// File: rtl/psram_xfer_arb.sv
// psram_xfer_arb: shares the psram_core transfer port between one config and two bus requesters.
// Ports: clk_i/rst_n_i (async active-low); cfg_req/rdwr in, cfg_gnt/done out;
//        bus_req/rdwr/addr/wdata/wmask in (2 ports), bus_gnt/done/rdata out;
//        err_o timeout flag; core: transfer port toward psram_core.
module psram_xfer_arb #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cfg_req_i,
    input  logic             cfg_rdwr_i,
    output logic             cfg_gnt_o,
    output logic             cfg_done_o,
    input  logic [1:0]       bus_req_i,
    input  logic [1:0]       bus_rdwr_i,
    input  logic [1:0][31:0] bus_addr_i,
    input  logic [1:0][63:0] bus_wdata_i,
    input  logic [1:0][7:0]  bus_wmask_i,
    output logic [1:0]       bus_gnt_o,
    output logic [1:0]       bus_done_o,
    output logic [63:0]      bus_rdata_o,
    output logic             err_o,
    psram_xfer_arb_if.master core
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  r_state;
    logic        r_rr;
    logic        r_own_cfg;
    logic        r_own_port;
    logic        r_rdwr;
    logic        r_err;
    logic [31:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wmask;
    logic [63:0] r_rdata;
    logic [31:0] r_cnt;
    logic        w_grant;
    logic        w_bus_gnt;
    logic        w_pick_port;
    logic        w_timeout;
    logic        w_resp_bus;

    always_comb begin
        // gated by rst_n_i so grants stay low while reset is held
        w_grant     = rst_n_i && r_state == S_IDLE && core.xfer_ready && (cfg_req_i || |bus_req_i);
        w_bus_gnt   = w_grant && !cfg_req_i;
        w_pick_port = bus_req_i[r_rr] ? r_rr : ~r_rr;
        w_timeout   = (r_state == S_ISSUE || r_state == S_WAIT) && r_cnt == 32'(TIMEOUT_CYC - 1);
        w_resp_bus  = r_state == S_RESP && !r_own_cfg;
    end

    assign cfg_gnt_o       = w_grant && cfg_req_i;
    assign bus_gnt_o       = {w_bus_gnt && w_pick_port, w_bus_gnt && !w_pick_port};
    assign cfg_done_o      = r_state == S_RESP && r_own_cfg;
    assign bus_done_o      = {w_resp_bus && r_own_port, w_resp_bus && !r_own_port};
    assign bus_rdata_o     = r_rdata;
    assign err_o           = r_err;
    assign core.xfer_valid = r_state == S_ISSUE;
    assign core.cflg       = r_own_cfg && r_state != S_IDLE;
    assign core.xfer_rdwr  = r_rdwr;
    assign core.addr       = r_addr;
    assign core.wdata      = r_wdata;
    assign core.wmask      = r_wmask;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_rr       <= 1'b0;
            r_own_cfg  <= 1'b0;
            r_own_port <= 1'b0;
            r_rdwr     <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_grant) begin
                    r_state    <= S_ISSUE;
                    r_cnt      <= '0;
                    r_own_cfg  <= cfg_req_i;
                    r_own_port <= w_pick_port;
                    r_rdwr     <= cfg_req_i ? cfg_rdwr_i : bus_rdwr_i[w_pick_port];
                    r_addr     <= cfg_req_i ? 32'd0 : bus_addr_i[w_pick_port];
                    r_wdata    <= cfg_req_i ? 64'd0 : bus_wdata_i[w_pick_port];
                    r_wmask    <= cfg_req_i ? 8'd0 : bus_wmask_i[w_pick_port];
                    r_rr       <= cfg_req_i ? r_rr : ~w_pick_port;
                end
                S_ISSUE, S_WAIT: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_timeout) begin
                        r_state <= S_RESP;
                        r_err   <= 1'b1;
                        r_rdata <= r_rdwr ? 64'd0 : r_rdata;
                    end else if (r_state == S_WAIT && core.xfer_done) begin
                        r_state <= S_RESP;
                        r_err   <= 1'b0;
                        r_rdata <= r_rdwr ? core.rd_data : r_rdata;
                    end else if (r_state == S_ISSUE && !core.xfer_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psram_xfer_arb.sv
// tb_psram_xfer_arb: directed tests for psram_xfer_arb with the core side driven by hand.
module tb_psram_xfer_arb;
    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             cfg_req_i, cfg_rdwr_i, cfg_gnt_o, cfg_done_o;
    logic [1:0]       bus_req_i, bus_rdwr_i, bus_gnt_o, bus_done_o;
    logic [1:0][31:0] bus_addr_i;
    logic [1:0][63:0] bus_wdata_i;
    logic [1:0][7:0]  bus_wmask_i;
    logic [63:0]      bus_rdata_o;
    logic             err_o;
    int               errors = 0;
    int               checks = 0;

    psram_xfer_arb_if cif();

    psram_xfer_arb #(.TIMEOUT_CYC(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cfg_req_i(cfg_req_i), .cfg_rdwr_i(cfg_rdwr_i), .cfg_gnt_o(cfg_gnt_o), .cfg_done_o(cfg_done_o),
        .bus_req_i(bus_req_i), .bus_rdwr_i(bus_rdwr_i), .bus_addr_i(bus_addr_i),
        .bus_wdata_i(bus_wdata_i), .bus_wmask_i(bus_wmask_i), .bus_gnt_o(bus_gnt_o),
        .bus_done_o(bus_done_o), .bus_rdata_o(bus_rdata_o), .err_o(err_o), .core(cif)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_i);
        #2;
    endtask

    task automatic test_reset;
        rst_n_i = 1'b0; cfg_req_i = 1'b1; cfg_rdwr_i = 1'b0;
        bus_req_i = 2'b11; bus_rdwr_i = 2'b00;
        bus_addr_i = '0; bus_wdata_i = '0; bus_wmask_i = '0;
        cif.xfer_ready = 1'b1; cif.xfer_done = 1'b1; cif.rd_data = '0;
        tick; tick;
        checks++; if ({cfg_gnt_o, bus_gnt_o} !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", {cfg_gnt_o, bus_gnt_o}); end
        checks++; if ({cfg_done_o, bus_done_o, err_o} !== 4'b0000) begin errors++; $display("FAIL reset_done_err got %b want 0000", {cfg_done_o, bus_done_o, err_o}); end
        checks++; if ({cif.xfer_valid, cif.cflg, cif.xfer_rdwr} !== 3'b000) begin errors++; $display("FAIL reset_core_ctl got %b want 000", {cif.xfer_valid, cif.cflg, cif.xfer_rdwr}); end
        checks++; if ({cif.addr, cif.wdata, cif.wmask} !== 104'd0) begin errors++; $display("FAIL reset_hold got %h want 0", {cif.addr, cif.wdata, cif.wmask}); end
        checks++; if (bus_rdata_o !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus_rdata_o); end
        cif.xfer_done = 1'b0;
        rst_n_i = 1'b1;
        #1;
    endtask

    task automatic test_arbitration;
        logic [2:0] exp [5];
        exp = '{3'b100, 3'b001, 3'b010, 3'b001, 3'b010};
        for (int i = 0; i < 5; i++) begin
            checks++; if ({cfg_gnt_o, bus_gnt_o} !== exp[i]) begin errors++; $display("FAIL arb_gnt[%0d] got %b want %b", i, {cfg_gnt_o, bus_gnt_o}, exp[i]); end
            tick;
            if (i == 0) cfg_req_i = 1'b0;
            checks++; if ({cif.xfer_valid, cif.cflg} !== {1'b1, i == 0}) begin errors++; $display("FAIL arb_issue[%0d] valid,cflg got %b want %b", i, {cif.xfer_valid, cif.cflg}, {1'b1, i == 0}); end
            cif.xfer_ready = 1'b0;
            tick;
            cif.xfer_done = 1'b1;
            tick;
            cif.xfer_done = 1'b0; cif.xfer_ready = 1'b1;
            checks++; if ({cfg_done_o, bus_done_o} !== exp[i]) begin errors++; $display("FAIL arb_done[%0d] got %b want %b", i, {cfg_done_o, bus_done_o}, exp[i]); end
            tick;
        end
        bus_req_i = 2'b00;
        tick;
    endtask

    task automatic test_bus_write;
        bus_req_i = 2'b01; bus_rdwr_i = 2'b00;
        bus_addr_i[0] = 32'h0000_0100; bus_wdata_i[0] = 64'h1122_3344_5566_7788; bus_wmask_i[0] = 8'hFF;
        #1;
        checks++; if ({cfg_gnt_o, bus_gnt_o} !== 3'b001) begin errors++; $display("FAIL wr_gnt got %b want 001", {cfg_gnt_o, bus_gnt_o}); end
        tick;
        bus_req_i = 2'b00; bus_addr_i[0] = 32'hFFFF_FFFF; bus_wdata_i[0] = '1; bus_wmask_i[0] = 8'h0F;
        checks++; if ({cif.xfer_valid, cif.cflg, cif.xfer_rdwr} !== 3'b100) begin errors++; $display("FAIL wr_issue_ctl got %b want 100", {cif.xfer_valid, cif.cflg, cif.xfer_rdwr}); end
        checks++; if (cif.addr !== 32'h100 || cif.wdata !== 64'h1122_3344_5566_7788 || cif.wmask !== 8'hFF) begin errors++; $display("FAIL wr_issue_hold got %h %h %h want 00000100 1122334455667788 ff", cif.addr, cif.wdata, cif.wmask); end
        cif.xfer_ready = 1'b0;
        tick;
        checks++; if (cif.xfer_valid !== 1'b0) begin errors++; $display("FAIL wr_wait_valid got %b want 0", cif.xfer_valid); end
        cif.xfer_done = 1'b1;
        #1;
        checks++; if (bus_done_o !== 2'b00) begin errors++; $display("FAIL wr_done_early got %b want 00", bus_done_o); end
        checks++; if (cif.addr !== 32'h100 || cif.wdata !== 64'h1122_3344_5566_7788 || cif.wmask !== 8'hFF) begin errors++; $display("FAIL wr_wait_hold got %h %h %h", cif.addr, cif.wdata, cif.wmask); end
        tick;
        cif.xfer_done = 1'b0; cif.xfer_ready = 1'b1;
        checks++; if ({cfg_done_o, bus_done_o, err_o} !== 4'b0010) begin errors++; $display("FAIL wr_done got %b want 0010", {cfg_done_o, bus_done_o, err_o}); end
        tick;
        checks++; if (bus_done_o !== 2'b00) begin errors++; $display("FAIL wr_done_len got %b want 00", bus_done_o); end
    endtask

    task automatic test_bus_read;
        bus_req_i = 2'b10; bus_rdwr_i = 2'b10; bus_addr_i[1] = 32'h0000_2000;
        #1;
        checks++; if (bus_gnt_o !== 2'b10) begin errors++; $display("FAIL rd_gnt got %b want 10", bus_gnt_o); end
        tick;
        bus_req_i = 2'b00;
        checks++; if ({cif.xfer_rdwr, cif.addr} !== {1'b1, 32'h2000}) begin errors++; $display("FAIL rd_issue got %h want 100002000", {cif.xfer_rdwr, cif.addr}); end
        cif.xfer_ready = 1'b0;
        tick;
        cif.xfer_done = 1'b1; cif.rd_data = 64'hDEAD_BEEF_CAFE_F00D;
        tick;
        cif.xfer_done = 1'b0; cif.xfer_ready = 1'b1; cif.rd_data = '0;
        checks++; if (bus_done_o !== 2'b10 || bus_rdata_o !== 64'hDEAD_BEEF_CAFE_F00D) begin errors++; $display("FAIL rd_done got %b %h want 10 deadbeefcafef00d", bus_done_o, bus_rdata_o); end
        tick;
    endtask

    task automatic test_timeout;
        bus_req_i = 2'b01; bus_rdwr_i = 2'b01;
        #1;
        checks++; if (bus_gnt_o !== 2'b01) begin errors++; $display("FAIL to_gnt got %b want 01", bus_gnt_o); end
        tick;
        bus_req_i = 2'b00; cif.xfer_ready = 1'b0;
        for (int i = 1; i < 16; i++) tick;
        checks++; if (bus_done_o !== 2'b00) begin errors++; $display("FAIL to_early got %b want 00", bus_done_o); end
        tick;
        checks++; if ({bus_done_o, err_o} !== 3'b011 || bus_rdata_o !== 64'd0) begin errors++; $display("FAIL to_done got %b err %b rdata %h want 01 1 0", bus_done_o, err_o, bus_rdata_o); end
        cif.xfer_ready = 1'b1;
        tick;
        checks++; if (bus_done_o !== 2'b00) begin errors++; $display("FAIL to_done_len got %b want 00", bus_done_o); end
    endtask

    task automatic test_spurious_done;
        cif.xfer_done = 1'b1;
        tick;
        cif.xfer_done = 1'b0;
        checks++; if ({cfg_done_o, bus_done_o, cif.xfer_valid} !== 4'b0000) begin errors++; $display("FAIL sp_idle got %b want 0000", {cfg_done_o, bus_done_o, cif.xfer_valid}); end
        bus_req_i = 2'b11; bus_rdwr_i = 2'b11;
        #1;
        checks++; if (bus_gnt_o !== 2'b10) begin errors++; $display("FAIL sp_gnt got %b want 10", bus_gnt_o); end
        tick;
        bus_req_i = 2'b00; cif.xfer_done = 1'b1;
        tick;
        cif.xfer_done = 1'b0;
        checks++; if ({bus_done_o, cif.xfer_valid} !== 3'b001) begin errors++; $display("FAIL sp_issue got %b want 001", {bus_done_o, cif.xfer_valid}); end
        cif.xfer_ready = 1'b0;
        tick;
        cif.xfer_done = 1'b1; cif.rd_data = 64'h0123_4567_89AB_CDEF;
        tick;
        cif.xfer_done = 1'b0; cif.xfer_ready = 1'b1;
        checks++; if ({bus_done_o, err_o} !== 3'b100 || bus_rdata_o !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL sp_done got %b err %b rdata %h want 10 0 0123456789abcdef", bus_done_o, err_o, bus_rdata_o); end
        tick;
    endtask

    task automatic test_reset_mid;
        bus_req_i = 2'b01; bus_rdwr_i = 2'b00; bus_addr_i[0] = 32'h0000_0300; bus_wmask_i[0] = 8'h3C;
        #1;
        checks++; if (bus_gnt_o !== 2'b01) begin errors++; $display("FAIL rm_gnt got %b want 01", bus_gnt_o); end
        tick;
        bus_req_i = 2'b00; cif.xfer_ready = 1'b0;
        tick;
        #1;
        rst_n_i = 1'b0;
        #1;
        checks++; if ({cif.xfer_valid, cif.cflg, cif.xfer_rdwr, bus_done_o, cfg_done_o, err_o} !== 7'd0) begin errors++; $display("FAIL rm_ctl got %b want 0", {cif.xfer_valid, cif.cflg, cif.xfer_rdwr, bus_done_o, cfg_done_o, err_o}); end
        checks++; if ({cif.addr, cif.wmask} !== 40'd0 || bus_rdata_o !== 64'd0) begin errors++; $display("FAIL rm_hold got %h rdata %h want 0", {cif.addr, cif.wmask}, bus_rdata_o); end
        tick;
        cif.xfer_ready = 1'b1; bus_req_i = 2'b11;
        rst_n_i = 1'b1;
        #1;
        checks++; if (bus_gnt_o !== 2'b01) begin errors++; $display("FAIL rm_rr got %b want 01", bus_gnt_o); end
        tick;
        bus_req_i = 2'b00;
        checks++; if ({cif.xfer_valid, cif.addr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL rm_issue got %h want 100000300", {cif.xfer_valid, cif.addr}); end
        cif.xfer_ready = 1'b0;
        tick;
        cif.xfer_done = 1'b1;
        tick;
        cif.xfer_done = 1'b0; cif.xfer_ready = 1'b1;
        checks++; if (bus_done_o !== 2'b01) begin errors++; $display("FAIL rm_done got %b want 01", bus_done_o); end
        tick;
    endtask

    initial begin
        test_reset;
        test_arbitration;
        test_bus_write;
        test_bus_read;
        test_timeout;
        test_spurious_done;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
